// File: rtl/key_fifo_typematic.sv
// Keyboard key queue with typematic auto-repeat in front of the CPU keyboard port.
// Define KEY_FIFO_REPEAT_EN to build the DELAY/REPEAT auto-repeat engine.
module key_fifo_typematic #(
    parameter int DW           = 8,
    parameter int DEPTH        = 64,
    parameter int REPEAT_DELAY = 300000,
    parameter int REPEAT_RATE  = 30000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   key_code,
    input  logic            rd_en,
    input  logic            clr_ovf,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid,
    output logic            empty,
    output logic            full,
    output logic [$clog2(DEPTH):0] count,
    output logic            overflow
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("key_fifo_typematic: illegal parameters");
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_nxt;
    logic [DW-1:0] prev;
    logic [DW-1:0] prev_nxt;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          key_on;

    assign key_on = (key_code != '0);

`ifdef KEY_FIFO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0] DLY_END  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_END = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Every push enqueues key_code: a repeat only fires while key_code == prev.
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        cnt_nxt   = cnt;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_on) begin
                    push      = 1'b1;
                    prev_nxt  = key_code;
                    cnt_nxt   = '0;
                    state_nxt = DELAY;
                end
            end
            DELAY: begin
                if (!key_on) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (key_code != prev) begin
                    push     = 1'b1;
                    prev_nxt = key_code;
                    cnt_nxt  = '0;
                end else if (cnt == DLY_END) begin
                    push      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = REPEAT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!key_on) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (key_code != prev) begin
                    push      = 1'b1;
                    prev_nxt  = key_code;
                    cnt_nxt   = '0;
                    state_nxt = DELAY;
                end else if (cnt == RATE_END) begin
                    push    = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    typedef enum logic [0:0] {IDLE, HELD} state_t;
    state_t state;
    state_t state_nxt;

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_on) begin
                    push      = 1'b1;
                    prev_nxt  = key_code;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (!key_on) begin
                    state_nxt = IDLE;
                end else if (key_code != prev) begin
                    push     = 1'b1;
                    prev_nxt = key_code;
                end
            end
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prev  <= '0;
        end else begin
            state <= state_nxt;
            prev  <= prev_nxt;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign pop     = rd_en && !empty;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_comb begin
        count_nxt = count;
        unique case ({push_ok, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= key_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == (AW+1)'(DEPTH));
            rd_valid <= pop;
            if (rd_en) begin
                rd_data <= pop ? mem[rd_ptr] : '0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_key_fifo_typematic.sv
// Directed bench for key_fifo_typematic with DEPTH=4, delay 8, rate 3.
// Expectations follow KEY_FIFO_REPEAT_EN when it is defined for the build.
module tb_key_fifo_typematic;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key_code;
    logic       rd_en;
    logic       clr_ovf;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

`ifdef KEY_FIFO_REPEAT_EN
    localparam int HOLD_N = 4;
`else
    localparam int HOLD_N = 1;
`endif

    key_fifo_typematic #(
        .DW(8), .DEPTH(4), .REPEAT_DELAY(8), .REPEAT_RATE(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .rd_en(rd_en),
        .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic [7:0] k);
        key_code = k;
        tick(1);
        key_code = 8'h00;
        tick(1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; key_code = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
        tick(2);
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_tap;
        key_code = 8'h41;
        tick(2);
        key_code = 8'h00;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL tap_count got=%0d exp=1", count); end
        rd_en = 1'b1;
        tick(1);
        total++; if (rd_data !== 8'h41) begin bad++; $display("FAIL tap_rd_data got=%h exp=41", rd_data); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL tap_rd_valid got=%b exp=1", rd_valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL tap_empty got=%b exp=1", empty); end
        tick(1);
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL tap_rd_empty got=%h exp=00", rd_data); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL tap_rd_valid2 got=%b exp=0", rd_valid); end
        rd_en = 1'b0;
        tick(1);
    endtask

    task automatic test_hold;
        key_code = 8'h42;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i == 1) begin
                total++; if (count !== 3'd1) begin bad++; $display("FAIL hold_first got=%0d exp=1", count); end
            end
`ifdef KEY_FIFO_REPEAT_EN
            if (i == 8) begin
                total++; if (count !== 3'd1) begin bad++; $display("FAIL hold_pre_delay got=%0d exp=1", count); end
            end
            if (i == 9) begin
                total++; if (count !== 3'd2) begin bad++; $display("FAIL hold_delay got=%0d exp=2", count); end
            end
            if (i == 12) begin
                total++; if (count !== 3'd3) begin bad++; $display("FAIL hold_rate1 got=%0d exp=3", count); end
            end
            if (i == 15) begin
                total++; if (count !== 3'd4) begin bad++; $display("FAIL hold_rate2 got=%0d exp=4", count); end
                total++; if (full !== 1'b1) begin bad++; $display("FAIL hold_full got=%b exp=1", full); end
            end
            if (i == 17) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL hold_ovf_early got=%b exp=0", overflow); end
            end
            if (i == 18) begin
                total++; if (overflow !== 1'b1) begin bad++; $display("FAIL hold_ovf got=%b exp=1", overflow); end
                total++; if (count !== 3'd4) begin bad++; $display("FAIL hold_drop_count got=%0d exp=4", count); end
            end
`else
            if (i == 20) begin
                total++; if (count !== 3'd1) begin bad++; $display("FAIL hold_norep_count got=%0d exp=1", count); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL hold_norep_ovf got=%b exp=0", overflow); end
            end
`endif
        end
        key_code = 8'h00;
        tick(1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL hold_clr got=%b exp=0", overflow); end
        rd_en = 1'b1;
        for (int i = 0; i < HOLD_N; i++) begin
            tick(1);
            total++; if (rd_data !== 8'h42) begin bad++; $display("FAIL hold_drain%0d got=%h exp=42", i, rd_data); end
        end
        rd_en = 1'b0;
        tick(1);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL hold_empty got=%b exp=1", empty); end
    endtask

    task automatic test_push_pop;
        logic [7:0] exp_q [4];
        exp_q = '{8'h62, 8'h63, 8'h64, 8'h50};
        for (int i = 0; i < 4; i++) tap(8'h61 + 8'(i));
        total++; if (full !== 1'b1) begin bad++; $display("FAIL pp_full got=%b exp=1", full); end
        key_code = 8'h50; rd_en = 1'b1;
        tick(1);
        key_code = 8'h00; rd_en = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL pp_full_count got=%0d exp=4", count); end
        total++; if (rd_data !== 8'h61) begin bad++; $display("FAIL pp_full_rd got=%h exp=61", rd_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_full_ovf got=%b exp=0", overflow); end
        tick(1);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            total++; if (rd_data !== exp_q[i]) begin bad++; $display("FAIL pp_drain%0d got=%h exp=%h", i, rd_data, exp_q[i]); end
        end
        key_code = 8'h51;
        tick(1);
        key_code = 8'h00;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL pp_empty_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL pp_empty_rd got=%h exp=00", rd_data); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL pp_empty_count got=%0d exp=1", count); end
        tick(1);
        total++; if (rd_data !== 8'h51) begin bad++; $display("FAIL pp_last got=%h exp=51", rd_data); end
        rd_en = 1'b0;
        tick(1);
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 10; i++) begin
            key_code = 8'h30 + 8'(i);
            tick(1);
            key_code = 8'h00; rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
            total++; if (rd_data !== 8'h30 + 8'(i) || rd_valid !== 1'b1) begin
                bad++; $display("FAIL wrap%0d got=%h/%b exp=%h/1", i, rd_data, rd_valid, 8'h30 + 8'(i));
            end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_switch;
        key_code = 8'h43;
        tick(4);
        key_code = 8'h44;
        tick(1);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL sw_count got=%0d exp=2", count); end
        tick(7);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL sw_restart got=%0d exp=2", count); end
        tick(1);
`ifdef KEY_FIFO_REPEAT_EN
        total++; if (count !== 3'd3) begin bad++; $display("FAIL sw_repeat got=%0d exp=3", count); end
`else
        total++; if (count !== 3'd2) begin bad++; $display("FAIL sw_norep got=%0d exp=2", count); end
`endif
        key_code = 8'h00; rd_en = 1'b1;
        tick(1);
        total++; if (rd_data !== 8'h43) begin bad++; $display("FAIL sw_first got=%h exp=43", rd_data); end
        tick(1);
        total++; if (rd_data !== 8'h44) begin bad++; $display("FAIL sw_second got=%h exp=44", rd_data); end
        tick(2);
        rd_en = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL sw_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid;
        tap(8'h71);
        tap(8'h72);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL rm_pre got=%0d exp=2", count); end
        key_code = 8'h55;
        #1 rst_n = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rm_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rm_empty got=%b exp=1", empty); end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        key_code = 8'h00;
        total++; if (count !== 3'd1) begin bad++; $display("FAIL rm_held got=%0d exp=1", count); end
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        total++; if (rd_data !== 8'h55) begin bad++; $display("FAIL rm_data got=%h exp=55", rd_data); end
    endtask

    initial begin
        test_reset();
        test_tap();
        test_hold();
        test_push_pop();
        test_wrap();
        test_switch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
